// File: rtl/axi_mem_arbiter_pkg.sv
// Shared widths, response encodings and routing types
// for the two-master AXI4-Lite memory arbiter.
package axi_mem_arbiter_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int ACERR_WIDTH = 2;
    localparam int STRB_WIDTH  = DATA_WIDTH / 8;

    localparam logic [ACERR_WIDTH-1:0] RESP_OKAY   = 2'b00;
    localparam logic [ACERR_WIDTH-1:0] RESP_SLVERR = 2'b10;
    localparam logic [ACERR_WIDTH-1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        OWN_IFU,
        OWN_LSU
    } owner_e;

    typedef struct packed {
        logic i_ar;
        logic i_r;
        logic l_ar;
        logic l_r;
        logic l_aw;
        logic l_b;
    } route_t;

endpackage

// File: rtl/axi_mem_arbiter_if.sv
// AXI4-Lite bundle; master drives address/data,
// slave drives readies and responses.
interface axi_mem_arbiter_if #(
    parameter int DW = axi_mem_arbiter_pkg::DATA_WIDTH,
    parameter int EW = axi_mem_arbiter_pkg::ACERR_WIDTH,
    parameter int SW = DW / 8
);
    logic [DW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [EW-1:0] rresp;
    logic          rvalid;
    logic          rready;
    logic [DW-1:0] awaddr;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wvalid;
    logic          wready;
    logic [EW-1:0] bresp;
    logic          bvalid;
    logic          bready;

    modport master (
        output araddr, arvalid, rready,
        output awaddr, awvalid,
        output wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        input  awaddr, awvalid,
        input  wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid,
        output awready, wready, bresp, bvalid
    );

endinterface

// File: rtl/axi_lite_mux.sv
// Combinational channel steering between the two masters
// and the shared slave, selected by the arbiter phase.
module axi_lite_mux
    import axi_mem_arbiter_pkg::*;
(
    input  route_t                  rt,
    input  logic                    aw_done,
    input  logic                    w_done,
    axi_mem_arbiter_if.slave        ifu,
    axi_mem_arbiter_if.slave        lsu,
    axi_mem_arbiter_if.master       mem
);

    // The fetch port is read-only; its write inputs are ignored.
    logic unused_ifu_wr;
    assign unused_ifu_wr = ^{ifu.awaddr, ifu.awvalid, ifu.wdata,
                             ifu.wstrb, ifu.wvalid, ifu.bready};

    always_comb begin
        mem.araddr  = '0;
        mem.arvalid = 1'b0;
        mem.rready  = 1'b0;
        mem.awaddr  = '0;
        mem.awvalid = 1'b0;
        mem.wdata   = '0;
        mem.wstrb   = '0;
        mem.wvalid  = 1'b0;
        mem.bready  = 1'b0;
        ifu.arready = 1'b0;
        ifu.rdata   = '0;
        ifu.rresp   = '0;
        ifu.rvalid  = 1'b0;
        ifu.awready = 1'b0;
        ifu.wready  = 1'b0;
        ifu.bresp   = '0;
        ifu.bvalid  = 1'b0;
        lsu.arready = 1'b0;
        lsu.rdata   = '0;
        lsu.rresp   = '0;
        lsu.rvalid  = 1'b0;
        lsu.awready = 1'b0;
        lsu.wready  = 1'b0;
        lsu.bresp   = '0;
        lsu.bvalid  = 1'b0;
        unique case (1'b1)
            rt.i_ar: begin
                mem.araddr  = ifu.araddr;
                mem.arvalid = ifu.arvalid;
                ifu.arready = mem.arready;
            end
            rt.i_r: begin
                mem.rready = ifu.rready;
                ifu.rdata  = mem.rdata;
                ifu.rresp  = mem.rresp;
                ifu.rvalid = mem.rvalid;
            end
            rt.l_ar: begin
                mem.araddr  = lsu.araddr;
                mem.arvalid = lsu.arvalid;
                lsu.arready = mem.arready;
            end
            rt.l_r: begin
                mem.rready = lsu.rready;
                lsu.rdata  = mem.rdata;
                lsu.rresp  = mem.rresp;
                lsu.rvalid = mem.rvalid;
            end
            rt.l_aw: begin
                // A completed AW or W beat is masked so it is never repeated.
                mem.awaddr  = lsu.awaddr;
                mem.awvalid = lsu.awvalid & ~aw_done;
                lsu.awready = mem.awready & ~aw_done;
                mem.wdata   = lsu.wdata;
                mem.wstrb   = lsu.wstrb;
                mem.wvalid  = lsu.wvalid & ~w_done;
                lsu.wready  = mem.wready & ~w_done;
            end
            rt.l_b: begin
                mem.bready = lsu.bready;
                lsu.bresp  = mem.bresp;
                lsu.bvalid = mem.bvalid;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/axi_mem_arbiter.sv
// Round-robin whole-transaction arbiter: IFU (read-only)
// and LSU (read/write) sharing one AXI4-Lite slave.
module axi_mem_arbiter
    import axi_mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    axi_mem_arbiter_if.slave  ifu,
    axi_mem_arbiter_if.slave  lsu,
    axi_mem_arbiter_if.master mem,
    output logic              Igrant,
    output logic              Lgrant,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE, I_AR, I_R, L_AR, L_R, L_AW, L_B
    } state_e;

    state_e state, state_n;
    owner_e last_owner, last_n;
    logic   aw_done, aw_done_n;
    logic   w_done, w_done_n;
    logic   ireq, lwr, lreq;
    logic   aw_all, w_all;
    route_t rt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= OWN_LSU;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            state      <= state_n;
            last_owner <= last_n;
            aw_done    <= aw_done_n;
            w_done     <= w_done_n;
        end
    end

    always_comb begin
        ireq      = ifu.arvalid;
        lwr       = lsu.awvalid & lsu.wvalid;
        lreq      = lsu.arvalid | lwr;
        aw_all    = aw_done | (mem.awvalid & mem.awready);
        w_all     = w_done | (mem.wvalid & mem.wready);
        state_n   = state;
        last_n    = last_owner;
        aw_done_n = aw_done;
        w_done_n  = w_done;
        unique case (state)
            IDLE: begin
                // On a tie the master that did not go last wins.
                if (ireq && (!lreq || last_owner == OWN_LSU)) begin
                    state_n = I_AR;
                    last_n  = OWN_IFU;
                end else if (lreq) begin
                    state_n = lwr ? L_AW : L_AR;
                    last_n  = OWN_LSU;
                end
            end
            I_AR: if (mem.arvalid && mem.arready) state_n = I_R;
            I_R:  if (mem.rvalid && mem.rready) state_n = IDLE;
            L_AR: if (mem.arvalid && mem.arready) state_n = L_R;
            L_R:  if (mem.rvalid && mem.rready) state_n = IDLE;
            L_AW: begin
                if (aw_all && w_all) begin
                    state_n   = L_B;
                    aw_done_n = 1'b0;
                    w_done_n  = 1'b0;
                end else begin
                    aw_done_n = aw_all;
                    w_done_n  = w_all;
                end
            end
            L_B:  if (mem.bvalid && mem.bready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        rt      = '0;
        rt.i_ar = (state == I_AR);
        rt.i_r  = (state == I_R);
        rt.l_ar = (state == L_AR);
        rt.l_r  = (state == L_R);
        rt.l_aw = (state == L_AW);
        rt.l_b  = (state == L_B);
    end

    assign Igrant = rt.i_ar | rt.i_r;
    assign Lgrant = rt.l_ar | rt.l_r | rt.l_aw | rt.l_b;
    assign busy   = (state != IDLE);

    axi_lite_mux u_mux (
        .rt      (rt),
        .aw_done (aw_done),
        .w_done  (w_done),
        .ifu     (ifu),
        .lsu     (lsu),
        .mem     (mem)
    );

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter: reset, round-robin,
// write ordering, LSU priority and error passthrough.
module tb_axi_mem_arbiter;
    import axi_mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic Igrant, Lgrant, busy;
    int   errors = 0;
    int   checks = 0;

    axi_mem_arbiter_if ifu_bus ();
    axi_mem_arbiter_if lsu_bus ();
    axi_mem_arbiter_if mem_bus ();

    axi_mem_arbiter dut (
        .clk    (clk),
        .reset  (reset),
        .ifu    (ifu_bus),
        .lsu    (lsu_bus),
        .mem    (mem_bus),
        .Igrant (Igrant),
        .Lgrant (Lgrant),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifu_bus.araddr = '0; ifu_bus.arvalid = 0; ifu_bus.rready = 0;
        ifu_bus.awaddr = '0; ifu_bus.awvalid = 0; ifu_bus.wdata = '0;
        ifu_bus.wstrb = '0; ifu_bus.wvalid = 0; ifu_bus.bready = 0;
        lsu_bus.araddr = '0; lsu_bus.arvalid = 0; lsu_bus.rready = 0;
        lsu_bus.awaddr = '0; lsu_bus.awvalid = 0; lsu_bus.wdata = '0;
        lsu_bus.wstrb = '0; lsu_bus.wvalid = 0; lsu_bus.bready = 0;
        mem_bus.arready = 0; mem_bus.rdata = '0; mem_bus.rresp = '0;
        mem_bus.rvalid = 0; mem_bus.awready = 0; mem_bus.wready = 0;
        mem_bus.bresp = '0; mem_bus.bvalid = 0;
    endtask

    task automatic test_reset();
        logic [13:0] outs;
        clear_inputs();
        reset = 1;
        ifu_bus.arvalid = 1; lsu_bus.arvalid = 1;
        lsu_bus.awvalid = 1; lsu_bus.wvalid = 1;
        mem_bus.rvalid = 1; mem_bus.bvalid = 1;
        mem_bus.arready = 1; mem_bus.awready = 1; mem_bus.wready = 1;
        tick(); tick(); #1;
        outs = {busy, Igrant, Lgrant, mem_bus.arvalid, mem_bus.awvalid,
                mem_bus.wvalid, mem_bus.rready, mem_bus.bready,
                ifu_bus.arready, ifu_bus.rvalid, lsu_bus.arready,
                lsu_bus.rvalid, lsu_bus.bvalid, lsu_bus.awready};
        checks++;
        if (outs !== 14'h0) begin
            errors++; $display("FAIL reset_outs got=%b exp=0", outs);
        end
        checks++;
        if ({ifu_bus.rdata, lsu_bus.rdata} !== 64'h0) begin
            errors++; $display("FAIL reset_rdata got=%h exp=0",
                               {ifu_bus.rdata, lsu_bus.rdata});
        end
        clear_inputs();
        reset = 0;
    endtask

    task automatic test_reset_mid();
        logic [9:0] outs;
        lsu_bus.araddr = 32'h100; lsu_bus.arvalid = 1;
        lsu_bus.rready = 1; mem_bus.arready = 1;
        tick(); #1;
        checks++;
        if ({Lgrant, mem_bus.arvalid, mem_bus.araddr} !== {2'b11, 32'h100}) begin
            errors++; $display("FAIL mid_lar got=%b%b/%h exp=11/100",
                               Lgrant, mem_bus.arvalid, mem_bus.araddr);
        end
        tick();
        lsu_bus.arvalid = 0; #1;
        checks++;
        if ({mem_bus.rready, busy, mem_bus.arvalid} !== 3'b110) begin
            errors++; $display("FAIL mid_lr got=%b exp=110",
                               {mem_bus.rready, busy, mem_bus.arvalid});
        end
        reset = 1;
        tick();
        reset = 0; #1;
        outs = {busy, Igrant, Lgrant, mem_bus.arvalid, mem_bus.rready,
                lsu_bus.arready, lsu_bus.rvalid, ifu_bus.arready,
                mem_bus.awvalid, mem_bus.wvalid};
        checks++;
        if (outs !== 10'h0) begin
            errors++; $display("FAIL mid_reset got=%b exp=0", outs);
        end
        clear_inputs();
    endtask

    task automatic test_tie();
        for (int rep = 0; rep < 2; rep++) begin
            clear_inputs();
            ifu_bus.araddr = 32'h8000_0010; ifu_bus.arvalid = 1;
            lsu_bus.araddr = 32'h0000_2000; lsu_bus.arvalid = 1;
            ifu_bus.rready = 1; lsu_bus.rready = 1; mem_bus.arready = 1;
            tick(); #1;
            checks++;
            if ({Igrant, Lgrant, lsu_bus.arready} !== 3'b100) begin
                errors++; $display("FAIL tie_first rep=%0d got=%b exp=100", rep,
                                   {Igrant, Lgrant, lsu_bus.arready});
            end
            checks++;
            if (mem_bus.araddr !== 32'h8000_0010) begin
                errors++; $display("FAIL tie_iaddr got=%h exp=80000010",
                                   mem_bus.araddr);
            end
            tick();
            ifu_bus.arvalid = 0; mem_bus.rvalid = 1;
            mem_bus.rdata = 32'h1111_0000 + rep; #1;
            checks++;
            if ({ifu_bus.rvalid, ifu_bus.rdata, lsu_bus.rvalid} !==
                {1'b1, 32'h1111_0000 + rep, 1'b0}) begin
                errors++; $display("FAIL tie_irdata got=%b/%h/%b exp=1/%h/0",
                                   ifu_bus.rvalid, ifu_bus.rdata,
                                   lsu_bus.rvalid, 32'h1111_0000 + rep);
            end
            tick();
            mem_bus.rvalid = 0; #1;
            checks++;
            if ({busy, Igrant, Lgrant} !== 3'b000) begin
                errors++; $display("FAIL tie_dead got=%b exp=000",
                                   {busy, Igrant, Lgrant});
            end
            tick(); #1;
            checks++;
            if ({Igrant, Lgrant, mem_bus.araddr} !== {2'b01, 32'h2000}) begin
                errors++; $display("FAIL tie_second got=%b%b/%h exp=01/2000",
                                   Igrant, Lgrant, mem_bus.araddr);
            end
            tick();
            lsu_bus.arvalid = 0; mem_bus.rvalid = 1;
            mem_bus.rdata = 32'h2222_0000 + rep; #1;
            checks++;
            if ({lsu_bus.rvalid, lsu_bus.rdata, ifu_bus.rdata} !==
                {1'b1, 32'h2222_0000 + rep, 32'h0}) begin
                errors++; $display("FAIL tie_lrdata got=%b/%h/%h exp=1/%h/0",
                                   lsu_bus.rvalid, lsu_bus.rdata,
                                   ifu_bus.rdata, 32'h2222_0000 + rep);
            end
            tick();
            mem_bus.rvalid = 0;
        end
    endtask

    task automatic test_ifu_alone();
        clear_inputs();
        ifu_bus.araddr = 32'h8000_0000; ifu_bus.arvalid = 1;
        ifu_bus.rready = 1; mem_bus.arready = 1; #1;
        checks++;
        if ({Igrant, busy, mem_bus.arvalid} !== 3'b000) begin
            errors++; $display("FAIL ifu_c0 got=%b exp=000",
                               {Igrant, busy, mem_bus.arvalid});
        end
        tick(); #1;
        checks++;
        if ({mem_bus.arvalid, ifu_bus.arready, Igrant, mem_bus.araddr} !==
            {3'b111, 32'h8000_0000}) begin
            errors++; $display("FAIL ifu_c1 got=%b%b%b/%h exp=111/80000000",
                               mem_bus.arvalid, ifu_bus.arready, Igrant,
                               mem_bus.araddr);
        end
        tick();
        ifu_bus.arvalid = 0; mem_bus.rvalid = 1;
        mem_bus.rdata = 32'h0000_0413; mem_bus.rresp = RESP_OKAY; #1;
        checks++;
        if ({ifu_bus.rvalid, ifu_bus.rdata, ifu_bus.rresp, Igrant,
             lsu_bus.rvalid, mem_bus.rready} !==
            {1'b1, 32'h413, 2'b00, 1'b1, 1'b0, 1'b1}) begin
            errors++; $display("FAIL ifu_c2 got=%b/%h/%b/%b%b%b exp=1/413/00/101",
                               ifu_bus.rvalid, ifu_bus.rdata, ifu_bus.rresp,
                               Igrant, lsu_bus.rvalid, mem_bus.rready);
        end
        tick();
        mem_bus.rvalid = 0; #1;
        checks++;
        if ({Igrant, busy, ifu_bus.rvalid} !== 3'b000) begin
            errors++; $display("FAIL ifu_c3 got=%b exp=000",
                               {Igrant, busy, ifu_bus.rvalid});
        end
    endtask

    task automatic test_write_w_first();
        clear_inputs();
        lsu_bus.wdata = 32'hDEAD_BEEF; lsu_bus.wstrb = 4'h3;
        lsu_bus.wvalid = 1; lsu_bus.awaddr = 32'h3000;
        lsu_bus.bready = 1; mem_bus.wready = 1; mem_bus.awready = 0;
        tick(); #1;
        checks++;
        if ({busy, mem_bus.wvalid, lsu_bus.wready} !== 3'b000) begin
            errors++; $display("FAIL lone_w got=%b exp=000",
                               {busy, mem_bus.wvalid, lsu_bus.wready});
        end
        tick();
        lsu_bus.awvalid = 1;
        tick(); #1;
        checks++;
        if ({mem_bus.wvalid, lsu_bus.wready, mem_bus.awvalid,
             lsu_bus.awready, Lgrant} !== 5'b11101) begin
            errors++; $display("FAIL w_first got=%b exp=11101",
                               {mem_bus.wvalid, lsu_bus.wready,
                                mem_bus.awvalid, lsu_bus.awready, Lgrant});
        end
        checks++;
        if ({mem_bus.wdata, mem_bus.wstrb} !== {32'hDEAD_BEEF, 4'h3}) begin
            errors++; $display("FAIL w_data got=%h/%h exp=deadbeef/3",
                               mem_bus.wdata, mem_bus.wstrb);
        end
        tick();
        mem_bus.awready = 1; #1;
        checks++;
        if ({mem_bus.wvalid, lsu_bus.wready, mem_bus.awvalid,
             lsu_bus.awready} !== 4'b0011) begin
            errors++; $display("FAIL aw_after got=%b exp=0011",
                               {mem_bus.wvalid, lsu_bus.wready,
                                mem_bus.awvalid, lsu_bus.awready});
        end
        checks++;
        if (mem_bus.awaddr !== 32'h3000) begin
            errors++; $display("FAIL aw_addr got=%h exp=3000", mem_bus.awaddr);
        end
        tick();
        lsu_bus.awvalid = 0; lsu_bus.wvalid = 0;
        mem_bus.bvalid = 1; mem_bus.bresp = RESP_OKAY; #1;
        checks++;
        if ({lsu_bus.bvalid, lsu_bus.bresp, mem_bus.bready,
             mem_bus.wvalid, Lgrant} !== 6'b100101) begin
            errors++; $display("FAIL w_bresp got=%b exp=100101",
                               {lsu_bus.bvalid, lsu_bus.bresp, mem_bus.bready,
                                mem_bus.wvalid, Lgrant});
        end
        tick();
        mem_bus.bvalid = 0; #1;
        checks++;
        if ({busy, Lgrant, lsu_bus.bvalid} !== 3'b000) begin
            errors++; $display("FAIL w_done got=%b exp=000",
                               {busy, Lgrant, lsu_bus.bvalid});
        end
    endtask

    task automatic test_priority_err();
        clear_inputs();
        lsu_bus.araddr = 32'h4000; lsu_bus.arvalid = 1;
        lsu_bus.awaddr = 32'h5000; lsu_bus.awvalid = 1;
        lsu_bus.wdata = 32'h55; lsu_bus.wstrb = 4'hF; lsu_bus.wvalid = 1;
        lsu_bus.bready = 1; lsu_bus.rready = 1; ifu_bus.rready = 1;
        mem_bus.arready = 1; mem_bus.awready = 1; mem_bus.wready = 1;
        tick(); #1;
        checks++;
        if ({mem_bus.arvalid, lsu_bus.arready, mem_bus.awvalid,
             mem_bus.wvalid} !== 4'b0011) begin
            errors++; $display("FAIL wr_first got=%b exp=0011",
                               {mem_bus.arvalid, lsu_bus.arready,
                                mem_bus.awvalid, mem_bus.wvalid});
        end
        tick();
        lsu_bus.awvalid = 0; lsu_bus.wvalid = 0;
        mem_bus.bvalid = 1; mem_bus.bresp = RESP_DECERR; #1;
        checks++;
        if ({lsu_bus.bvalid, lsu_bus.bresp, mem_bus.arvalid} !== 4'b1110) begin
            errors++; $display("FAIL wr_same_cycle got=%b exp=1110",
                               {lsu_bus.bvalid, lsu_bus.bresp, mem_bus.arvalid});
        end
        tick();
        mem_bus.bvalid = 0; #1;
        checks++;
        if ({busy, lsu_bus.bvalid, mem_bus.arvalid} !== 3'b000) begin
            errors++; $display("FAIL wr_idle got=%b exp=000",
                               {busy, lsu_bus.bvalid, mem_bus.arvalid});
        end
        tick(); #1;
        checks++;
        if ({Lgrant, mem_bus.arvalid, mem_bus.araddr} !== {2'b11, 32'h4000}) begin
            errors++; $display("FAIL rd_after got=%b%b/%h exp=11/4000",
                               Lgrant, mem_bus.arvalid, mem_bus.araddr);
        end
        tick();
        lsu_bus.arvalid = 0; mem_bus.rvalid = 1;
        mem_bus.rresp = RESP_SLVERR; mem_bus.rdata = 32'hBAD;
        ifu_bus.araddr = 32'h8000_0100; ifu_bus.arvalid = 1; #1;
        checks++;
        if ({lsu_bus.rvalid, lsu_bus.rresp, lsu_bus.rdata, ifu_bus.arready} !==
            {1'b1, 2'b10, 32'hBAD, 1'b0}) begin
            errors++; $display("FAIL slverr got=%b/%b/%h/%b exp=1/10/bad/0",
                               lsu_bus.rvalid, lsu_bus.rresp, lsu_bus.rdata,
                               ifu_bus.arready);
        end
        tick();
        mem_bus.rvalid = 0; mem_bus.rresp = RESP_OKAY; #1;
        checks++;
        if ({busy, Igrant, Lgrant} !== 3'b000) begin
            errors++; $display("FAIL err_idle got=%b exp=000",
                               {busy, Igrant, Lgrant});
        end
        tick(); #1;
        checks++;
        if ({Igrant, mem_bus.arvalid, mem_bus.araddr} !==
            {2'b11, 32'h8000_0100}) begin
            errors++; $display("FAIL err_next_ifu got=%b%b/%h exp=11/80000100",
                               Igrant, mem_bus.arvalid, mem_bus.araddr);
        end
        tick();
        ifu_bus.arvalid = 0; mem_bus.rvalid = 1; mem_bus.rdata = 32'h13; #1;
        checks++;
        if ({ifu_bus.rvalid, ifu_bus.rdata} !== {1'b1, 32'h13}) begin
            errors++; $display("FAIL err_ifu_rd got=%b/%h exp=1/13",
                               ifu_bus.rvalid, ifu_bus.rdata);
        end
        tick();
        mem_bus.rvalid = 0; #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL err_end got=%b exp=0", busy);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_reset_mid();
        test_tie();
        test_ifu_alone();
        test_write_w_first();
        test_priority_err();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_mem_arbiter.md
Name: axi_mem_arbiter

Overview:
Two-master to one-slave AXI4-Lite arbiter that shares the single memory port between the instruction-fetch unit (IFU, read-only) and the load/store unit (LSU, read and write).
- Grants one whole transaction at a time: address, then data, then response.
- Holds the grant until the response handshake completes.
- Exports per-master grant strobes that tell each master when returned data belongs to it.
- Sits between the fetch/LSU memory front-ends and the SRAM/AXI slave.

Parameters:
DATA_WIDTH, 32, address/data width
ACERR_WIDTH, 2, rresp/bresp width
STRB_WIDTH, DATA_WIDTH/8, write-strobe width

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high reset
i_araddr / i_arvalid  in  DATA_WIDTH / 1  IFU read address; i_arready out 1
i_rdata / i_rresp / i_rvalid  out  DATA_WIDTH / ACERR_WIDTH / 1  IFU read data; i_rready in 1
l_araddr / l_arvalid  in  DATA_WIDTH / 1  LSU read address; l_arready out 1
l_rdata / l_rresp / l_rvalid  out  DATA_WIDTH / ACERR_WIDTH / 1  LSU read data; l_rready in 1
l_awaddr / l_awvalid  in  DATA_WIDTH / 1  LSU write address; l_awready out 1
l_wdata / l_wstrb / l_wvalid  in  DATA_WIDTH / STRB_WIDTH / 1  LSU write data; l_wready out 1
l_bresp / l_bvalid  out  ACERR_WIDTH / 1  LSU write response; l_bready in 1
m_araddr / m_arvalid  out  DATA_WIDTH / 1  slave read address; m_arready in 1
m_rdata / m_rresp / m_rvalid  in  DATA_WIDTH / ACERR_WIDTH / 1  slave read data; m_rready out 1
m_awaddr / m_awvalid  out  DATA_WIDTH / 1  slave write address; m_awready in 1
m_wdata / m_wstrb / m_wvalid  out  DATA_WIDTH / STRB_WIDTH / 1  slave write data; m_wready in 1
m_bresp / m_bvalid  in  ACERR_WIDTH / 1  slave write response; m_bready out 1
Igrant  out  1  IFU owns the slave
Lgrant  out  1  LSU owns the slave
busy  out  1  state != IDLE

Behaviour:
- Clock `clk`, reset `reset`: one clock; reset is synchronous and active-high.
- FSM states: IDLE, I_AR, I_R, L_AR, L_R, L_AW, L_B. Registered state; all channel routing is combinational from state.
- Reset (including mid-transaction): state=IDLE, last_owner=LSU, aw_done=w_done=0.
  - All outputs 0: every m_*valid, m_rready, m_bready, all master-side ready/valid, Igrant, Lgrant, busy.
  - Any in-flight slave transaction is abandoned; the slave is reset by the same reset.
- IDLE arbitration:
  - ireq = i_arvalid.
  - lwr = l_awvalid & l_wvalid.
  - lreq = l_arvalid | lwr.
  - If only one requester is present, it wins.
  - If both are present, the master != last_owner wins (round-robin), so the first tie after reset goes to the IFU.
  - The winner is recorded in last_owner.
  - Within the LSU, a write (lwr) beats l_arvalid. A lone l_awvalid without l_wvalid is not a request.
- Next state from IDLE: I_AR, L_AW, or L_AR. The decision at edge N drives m_*valid in cycle N+1.
- I_AR / L_AR:
  - m_araddr = owner araddr; m_arvalid = owner arvalid; owner arready = m_arready.
  - On m_arvalid & m_arready, go to I_R / L_R.
- I_R / L_R:
  - m_rready = owner rready; owner rdata/rresp/rvalid = slave values.
  - On m_rvalid & m_rready, go to IDLE.
- L_AW:
  - m_awvalid = l_awvalid & ~aw_done; m_wvalid = l_wvalid & ~w_done; readies forwarded likewise.
  - aw_done and w_done are set on their respective handshakes, which may occur in either order or in the same cycle.
  - When both are done (including the same cycle), go to L_B and clear both flags.
- L_B:
  - m_bready = l_bready; l_bresp/l_bvalid forwarded.
  - On handshake, go to IDLE.
- Non-owner master: every ready and valid it sees is 0. Its rdata/rresp/bresp are 0, never stale.
- Responses: rresp/bresp pass through unmodified. Error responses end the transaction exactly like OKAY.
- Grant strobes:
  - Igrant = state in {I_AR, I_R}; Lgrant = state in {L_AR, L_R, L_AW, L_B}.
  - Never both 1. Both 0 in IDLE.
- Throughput: one dead IDLE cycle between back-to-back transactions. A single-cycle-ready slave gives a 3-cycle read (IDLE, AR, R).
- Masters must hold address/data stable while valid (AXI rule); the arbiter does not latch them.
- A master dropping valid before its handshake keeps the grant (no timeout); the FSM waits.

Decomposition:
- Shared package/defines: DATA_WIDTH, ACERR_WIDTH, and the RESP_OKAY/SLVERR/DECERR encodings.
- The FSM state enum lives locally in the module.
- One natural sub-module, axi_lite_mux: purely combinational channel steering selected by owner/phase, keeping the FSM file small.

Test Plan:
- Reset mid-L_R: assert reset for 1 cycle while m_rvalid=0 -> next cycle state IDLE, all valids/readies/grants 0, busy 0.
- IFU alone: i_araddr=0x8000_0000, slave arready=1, rdata=0x0000_0413 after 1 cycle -> m_arvalid in cycle 1, i_rvalid/i_rdata=0x413 in cycle 2, Igrant 1 for cycles 1–2, l_rvalid stays 0.
- Simultaneous tie after reset: i_arvalid=1, l_arvalid=1 in the same cycle -> IFU served first, then LSU. A second tie -> IFU first again because last_owner is LSU.
- LSU write with W before AW: l_wvalid at t, l_awvalid at t+2, slave accepts each immediately -> single m_wvalid pulse accepted, then m_awvalid accepted, then L_B. l_bresp=OKAY; no duplicate W beat.
- Write/read priority inside the LSU: l_arvalid=1 and lwr=1 together -> write completes first (bvalid handshake), read granted only after the next IDLE.
- Error path: slave returns rresp=2'b10 (SLVERR) to the LSU -> l_rresp=2'b10, FSM returns to IDLE, and the next IFU request is granted normally.
